// File: rtl/mult16_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// mult16_issue_ctrl_if
//   Bundles every handshake, multiplier and status signal of
//   mult16_issue_ctrl so the controller and its environment share one
//   connection.
//
//   Parameter DEPTH sizes fifo_count to $clog2(DEPTH)+1 bits. It must match
//   the DEPTH of the controller attached to the slave modport.
//
//   Signal groups:
//     operand in : in_valid, in_ready, in_a[15:0], in_b[15:0]
//     multiplier : mul_start, mul_ain[15:0], mul_bin[15:0],
//                  mul_yout[31:0], mul_done
//     result out : res_valid, res_ready, res_data[31:0], res_err
//     status     : busy, fifo_count
//
//   Modports:
//     slave  - the issue controller
//     master - the environment: operand source, multiplier and result sink
// ---------------------------------------------------------------------------
interface mult16_issue_ctrl_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_a;
  logic [15:0]   in_b;

  logic          mul_start;
  logic [15:0]   mul_ain;
  logic [15:0]   mul_bin;
  logic [31:0]   mul_yout;
  logic          mul_done;

  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res_data;
  logic          res_err;

  logic          busy;
  logic [CW-1:0] fifo_count;

  modport slave (
    input  in_valid, in_a, in_b, mul_yout, mul_done, res_ready,
    output in_ready, mul_start, mul_ain, mul_bin,
           res_valid, res_data, res_err, busy, fifo_count
  );

  modport master (
    output in_valid, in_a, in_b, mul_yout, mul_done, res_ready,
    input  in_ready, mul_start, mul_ain, mul_bin,
           res_valid, res_data, res_err, busy, fifo_count
  );
endinterface

// File: rtl/mult16_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mult16_issue_ctrl
//   Sequences the operands for a 16-bit shift-add multiplier and collects
//   its results. Operand pairs are queued in a DEPTH-entry FIFO. Pairs are
//   issued one at a time with a single-cycle mul_start. Each 32-bit product
//   is returned on a valid/ready result port. Only one result is
//   outstanding at a time, so results leave in push order.
//
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - mult16_issue_ctrl_if.slave: operand input, multiplier
//            start/operands/product/done, result output, busy, fifo_count
//
//   Parameters:
//     DEPTH       - operand FIFO depth. Must be a power of 2 and >= 2.
//     TIMEOUT_CYC - WAIT-state cycle limit. Used only with the timeout build.
//
//   Build option:
//     MULT16_ISSUE_TIMEOUT_EN - when defined, a stalled multiplier is
//       abandoned after TIMEOUT_CYC WAIT cycles. The block then returns
//       res_data=0 with res_err=1. When undefined, WAIT is unbounded and
//       res_err is tied to 0.
// ---------------------------------------------------------------------------
module mult16_issue_ctrl #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input logic               clk,
  input logic               rst,
  mult16_issue_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("mult16_issue_ctrl: DEPTH must be a power of 2 >= 2, TIMEOUT_CYC >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPT,
    S_OUT
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;
  logic          wait_first;
  logic          timeout;
  logic [15:0]   ain_q, bin_q;
  logic          res_valid_q;
  logic [31:0]   res_data_q;

  assign bus.in_ready   = ~rst & (count != CW'(DEPTH));
  assign push           = bus.in_valid & bus.in_ready;
  assign bus.fifo_count = count;
  assign bus.busy       = (state != S_IDLE);
  assign bus.mul_start  = (state == S_ISSUE);
  assign bus.mul_ain    = ain_q;
  assign bus.mul_bin    = bin_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;

  // NOTE: storage is deliberately not reset. Entries are only read after a
  // push has written them, and leaving reset off lets the array map onto
  // plain memory cells.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.in_a, bus.in_b};
  end

  // NOTE: clocked state uses non-blocking assignments only. Every register
  // then samples pre-edge values, regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef MULT16_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wait_cnt;
  logic          res_err_q;

  // The counter is held at zero outside WAIT, so every entry starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  wait_cnt <= '0;
    else if (state != S_WAIT) wait_cnt <= '0;
    else                      wait_cnt <= wait_cnt + TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  res_err_q <= 1'b0;
    else if (state == S_CAPT) res_err_q <= 1'b0;
    else if (timeout)         res_err_q <= 1'b1;
  end

  assign bus.res_err = res_err_q;
`else
  assign bus.res_err = 1'b0;
`endif

  // NOTE: every output of this block gets a default before the case. This
  // avoids latches on paths where a branch leaves a signal unassigned.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        // A done left high by the previous operation may still be visible
        // in the first WAIT cycle, so it is ignored there.
        if (!wait_first && bus.mul_done) begin
          state_nxt = S_CAPT;
        end
`ifdef MULT16_ISSUE_TIMEOUT_EN
        else if (wait_cnt == TW'(TIMEOUT_CYC - 1)) begin
          timeout   = 1'b1;
          state_nxt = S_OUT;
        end
`endif
      end
      S_CAPT: state_nxt = S_OUT;
      S_OUT: begin
        if (bus.res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_first <= 1'b0;
      ain_q      <= '0;
      bin_q      <= '0;
    end else begin
      state      <= state_nxt;
      wait_first <= (state == S_ISSUE);
      if (pop) {ain_q, bin_q} <= fifo_mem[rd_ptr];
    end
  end

  // The product is taken in CAPT, one edge after done is first seen. That
  // is the first edge at which the multiplier guarantees mul_yout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else if (state == S_CAPT) begin
      res_valid_q <= 1'b1;
      res_data_q  <= bus.mul_yout;
    end else if (timeout) begin
      res_valid_q <= 1'b1;
      res_data_q  <= '0;
    end else if (state == S_OUT && bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mult16_issue_ctrl.sv
module tb_mult16_issue_ctrl;
  localparam int DEPTH       = 4;
  localparam int TIMEOUT_CYC = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult16_issue_ctrl_if #(.DEPTH(DEPTH)) bus ();

  mult16_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cnt = 0;
  int last_start_cyc = 0;
  int last_hs_cyc = 0;
  bit mul_en = 1'b1;

  // Edge-sampled activity monitor: start pulses and result handshakes.
  always @(posedge clk) begin
    if (bus.res_valid && bus.res_ready) last_hs_cyc = cyc;
    if (bus.mul_start) begin
      start_cnt++;
      last_start_cyc = cyc;
    end
    cyc++;
  end

  // 16-step multiplier model. done from the previous operation lingers one
  // edge past start. yout becomes valid one edge after done rises; before
  // that it holds a poison value.
  logic [4:0]  m_cnt;
  logic        m_clr, m_load;
  logic [31:0] m_prod;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mul_done <= 1'b0;
      bus.mul_yout <= '0;
      m_cnt  <= '0;
      m_clr  <= 1'b0;
      m_load <= 1'b0;
      m_prod <= '0;
    end else if (bus.mul_start) begin
      m_prod       <= 32'(bus.mul_ain) * 32'(bus.mul_bin);
      m_cnt        <= 5'd16;
      m_clr        <= 1'b1;
      m_load       <= 1'b0;
      bus.mul_yout <= 32'hDEAD_BEEF;
    end else begin
      if (m_clr) begin
        bus.mul_done <= 1'b0;
        m_clr        <= 1'b0;
      end
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 5'd1;
        if (m_cnt == 5'd1 && mul_en) begin
          bus.mul_done <= 1'b1;
          m_load       <= 1'b1;
        end
      end
      if (m_load) begin
        bus.mul_yout <= m_prod;
        m_load       <= 1'b0;
      end
    end
  end

  task automatic push(input logic [15:0] a, input logic [15:0] b, output bit acc);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    acc          = bus.in_ready;
  endtask

  task automatic push_end();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    int i = 0;
    while (!bus.res_valid && i < max_cyc) begin
      @(negedge clk);
      i++;
    end
    ok = bus.res_valid;
  endtask

  task automatic get_result(input string name, input logic [31:0] exp_data,
                            input logic exp_err, input int max_cyc);
    bit ok;
    wait_valid(max_cyc, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: res_valid got 0, expected 1 within %0d cycles", name, max_cyc);
    end else begin
      n_vec++;
      if (bus.res_data !== exp_data) begin
        n_err++;
        $display("FAIL %s data: got %h expected %h", name, bus.res_data, exp_data);
      end
      n_vec++;
      if (bus.res_err !== exp_err) begin
        n_err++;
        $display("FAIL %s err: got %b expected %b", name, bus.res_err, exp_err);
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.res_valid, bus.res_err, bus.mul_start, bus.busy, bus.in_ready} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got rv=%b err=%b st=%b busy=%b rdy=%b expected all 0",
               bus.res_valid, bus.res_err, bus.mul_start, bus.busy, bus.in_ready);
    end
    n_vec++;
    if ({bus.res_data, bus.mul_ain, bus.mul_bin} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_data: got res=%h a=%h b=%h expected 0", bus.res_data, bus.mul_ain, bus.mul_bin);
    end
    n_vec++;
    if (bus.fifo_count !== 3'd0) begin
      n_err++;
      $display("FAIL reset_count: got %0d expected 0", bus.fifo_count);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready_after: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_single();
    bit acc;
    bit ok;
    int s0, t0, lat;
    bus.res_ready = 1'b1;
    s0 = start_cnt;
    push(16'h1234, 16'h0010, acc);
    push_end();
    t0 = cyc;
    n_vec++;
    if (acc !== 1'b1 || bus.fifo_count !== 3'd1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_push: got acc=%b count=%0d busy=%b expected 1/1/0", acc, bus.fifo_count, bus.busy);
    end
    wait_valid(100, ok);
    lat = cyc - t0;
    n_vec++;
    if (lat !== 20) begin
      n_err++;
      $display("FAIL single_latency: got %0d expected 20", lat);
    end
    n_vec++;
    if (bus.res_data !== 32'h0001_2340 || bus.res_err !== 1'b0) begin
      n_err++;
      $display("FAIL single_result: got %h err=%b expected 00012340 err=0", bus.res_data, bus.res_err);
    end
    n_vec++;
    if (bus.mul_ain !== 16'h1234 || bus.mul_bin !== 16'h0010) begin
      n_err++;
      $display("FAIL single_operands: got %h %h expected 1234 0010", bus.mul_ain, bus.mul_bin);
    end
    @(negedge clk);
    n_vec++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || (start_cnt - s0) !== 1) begin
      n_err++;
      $display("FAIL single_after: got rv=%b busy=%b starts=%0d expected 0/0/1",
               bus.res_valid, bus.busy, start_cnt - s0);
    end
    bus.res_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit acc0, acc1, ok;
    int s0, hs1;
    bus.res_ready = 1'b0;
    s0 = start_cnt;
    push(16'hFFFF, 16'hFFFF, acc0);
    push(16'h0000, 16'hABCD, acc1);
    push_end();
    wait_valid(100, ok);
    repeat (5) @(negedge clk);
    n_vec++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 32'hFFFE_0001 || (start_cnt - s0) !== 1 ||
        bus.fifo_count !== 3'd1) begin
      n_err++;
      $display("FAIL b2b_hold: got rv=%b data=%h starts=%0d count=%0d expected 1/fffe0001/1/1",
               bus.res_valid, bus.res_data, start_cnt - s0, bus.fifo_count);
    end
    get_result("b2b_first", 32'hFFFE_0001, 1'b0, 10);
    hs1 = last_hs_cyc;
    get_result("b2b_second", 32'h0000_0000, 1'b0, 100);
    n_vec++;
    if ((start_cnt - s0) !== 2 || !(last_start_cyc > hs1)) begin
      n_err++;
      $display("FAIL b2b_issue_order: got starts=%0d start_cyc=%0d hs_cyc=%0d expected 2 starts after handshake",
               start_cnt - s0, last_start_cyc, hs1);
    end
    n_vec++;
    if (bus.mul_ain !== 16'h0000 || bus.mul_bin !== 16'hABCD) begin
      n_err++;
      $display("FAIL b2b_operands: got %h %h expected 0000 abcd", bus.mul_ain, bus.mul_bin);
    end
  endtask

  task automatic test_fifo_full();
    logic [15:0] ta [5]   = '{16'h0100, 16'h8000, 16'h00FF, 16'h1111, 16'hAAAA};
    logic [15:0] tb [5]   = '{16'h0100, 16'h0003, 16'h00FF, 16'h0011, 16'h0002};
    logic [31:0] texp [4] = '{32'h0001_0000, 32'h0001_8000, 32'h0000_FE01, 32'h0001_2221};
    bit acc [5];
    bit a0, ok, seen;
    bus.res_ready = 1'b0;
    push(16'h0003, 16'h0005, a0);
    push_end();
    wait_valid(100, ok);
    for (int i = 0; i < 5; i++) push(ta[i], tb[i], acc[i]);
    push_end();
    n_vec++;
    if ({acc[0], acc[1], acc[2], acc[3], acc[4]} !== 5'b11110) begin
      n_err++;
      $display("FAIL full_accept: got %b%b%b%b%b expected 11110", acc[0], acc[1], acc[2], acc[3], acc[4]);
    end
    n_vec++;
    if (bus.fifo_count !== 3'(DEPTH) || bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_state: got count=%0d rdy=%b expected %0d/0", bus.fifo_count, bus.in_ready, DEPTH);
    end
    get_result("full_head", 32'h0000_000F, 1'b0, 10);
    for (int i = 0; i < 4; i++) get_result($sformatf("full_q%0d", i), texp[i], 1'b0, 100);
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      seen |= bus.res_valid;
    end
    n_vec++;
    if (seen !== 1'b0 || bus.fifo_count !== 3'd0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL full_drained: got extra=%b count=%0d busy=%b expected 0/0/0", seen, bus.fifo_count, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    bit seen;
    int s0;
    bus.res_ready = 1'b1;
    push(16'h0011, 16'h0022, acc);
    push(16'h0033, 16'h0044, acc);
    push(16'h0055, 16'h0066, acc);
    push_end();
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b1 || bus.fifo_count !== 3'd2) begin
      n_err++;
      $display("FAIL midrst_pre: got busy=%b count=%0d expected 1/2", bus.busy, bus.fifo_count);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.fifo_count !== 3'd0 || bus.res_valid !== 1'b0 || bus.mul_start !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_in: got count=%0d rv=%b st=%b busy=%b expected 0/0/0/0",
               bus.fifo_count, bus.res_valid, bus.mul_start, bus.busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s0 = start_cnt;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      seen |= bus.res_valid;
    end
    n_vec++;
    if (seen !== 1'b0 || start_cnt !== s0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_after: got rv_seen=%b starts=%0d busy=%b rdy=%b expected 0/0/0/1",
               seen, start_cnt - s0, bus.busy, bus.in_ready);
    end
    bus.res_ready = 1'b0;
  endtask

  task automatic test_timeout();
    bit acc;
    int t0;
    mul_en = 1'b0;
    bus.res_ready = 1'b0;
    push(16'h0002, 16'h0003, acc);
    push_end();
    t0 = cyc;
`ifdef MULT16_ISSUE_TIMEOUT_EN
    begin
      bit ok;
      wait_valid(TIMEOUT_CYC + 40, ok);
      n_vec++;
      if ((cyc - t0) !== TIMEOUT_CYC + 2) begin
        n_err++;
        $display("FAIL timeout_latency: got %0d expected %0d", cyc - t0, TIMEOUT_CYC + 2);
      end
      get_result("timeout_result", 32'h0, 1'b1, 5);
      n_vec++;
      if (bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL timeout_idle: got busy=%b expected 0", bus.busy);
      end
    end
`else
    begin
      bit seen = 1'b0;
      repeat (TIMEOUT_CYC + 40) begin
        @(negedge clk);
        seen |= bus.res_valid;
      end
      n_vec++;
      if (seen !== 1'b0 || bus.busy !== 1'b1 || bus.res_err !== 1'b0) begin
        n_err++;
        $display("FAIL no_timeout_wait: got rv_seen=%b busy=%b err=%b after %0d cycles expected 0/1/0",
                 seen, bus.busy, bus.res_err, cyc - t0);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_vec++;
      if (bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL no_timeout_recover: got busy=%b expected 0", bus.busy);
      end
    end
`endif
    mul_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
